full_st0_data_buffer: RTL and testbench

Data memory and read-alignment stage directly downstream of the stage-0 FIFO controller.
- Captures input words at the controller's write address.
- Serves reads at the controller's read address.
- Delays read data and valid so that they arrive aligned with the controller's delayed `active` strobe.
- Tracks per-row occupancy and flags writes into a row that has not yet been drained.

---
 rtl/full_st0_data_buffer_pkg.sv | 34 +++
 rtl/full_st0_data_buffer_if.sv | 40 ++++
 rtl/full_st0_delay_line.sv | 51 +++++
 rtl/full_st0_data_buffer.sv | 162 ++++++++++++++++
 tb/tb_full_st0_data_buffer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/full_st0_data_buffer_pkg.sv
// ----------------------------------------------------------------------------
// full_st0_data_buffer_pkg
// Shared constants, the float_24_8 word type and address helpers for the
// stage-0 data buffer. The buffer geometry defaults come from here.
// Optional build macro used by the buffer: FULL_ST0_BUF_BYPASS_EN.
// ----------------------------------------------------------------------------
package full_st0_data_buffer_pkg;

    localparam int BUF_DATA_WIDTH  = 32;
    localparam int BUF_ROW_BITS    = 3;
    localparam int BUF_COL_BITS    = 3;
    localparam int BUF_ALIGN_DELAY = 10;
    localparam int BUF_ADDR_BITS   = BUF_ROW_BITS + BUF_COL_BITS;
    localparam int BUF_NUM_ROWS    = 2 ** BUF_ROW_BITS;

    // float_24_8: 24-bit mantissa field above an 8-bit exponent field
    typedef struct packed {
        logic [23:0] mantissa;
        logic [7:0]  exponent;
    } float_24_8_t;

    typedef logic [BUF_ADDR_BITS-1:0] addr_t;

    // Row index is the upper part of a {row,col} address
    function automatic logic [BUF_ROW_BITS-1:0] addr_row(input addr_t addr);
        return addr[BUF_ADDR_BITS-1:BUF_COL_BITS];
    endfunction

    // Column index is the lower part of a {row,col} address
    function automatic logic [BUF_COL_BITS-1:0] addr_col(input addr_t addr);
        return addr[BUF_COL_BITS-1:0];
    endfunction

endpackage

// File: rtl/full_st0_data_buffer_if.sv
// ----------------------------------------------------------------------------
// full_st0_data_buffer_if
// Bundle of write, read-control and status signals between the stage-0 FIFO
// controller side (master) and the data buffer (slave).
//   write : data_valid, data_write_addr, data_value
//   read  : data_read_addr, active_normal, load_finish, load_length
//   status: err_clear (in); rd_data, rd_valid, row_full, rows_occupied,
//           overflow_err (out of the buffer)
// ----------------------------------------------------------------------------
interface full_st0_data_buffer_if #(
    parameter int DATA_WIDTH = full_st0_data_buffer_pkg::BUF_DATA_WIDTH,
    parameter int ROW_BITS   = full_st0_data_buffer_pkg::BUF_ROW_BITS,
    parameter int COL_BITS   = full_st0_data_buffer_pkg::BUF_COL_BITS
);
    logic                         data_valid;
    logic [ROW_BITS+COL_BITS-1:0] data_write_addr;
    logic [DATA_WIDTH-1:0]        data_value;
    logic [ROW_BITS+COL_BITS-1:0] data_read_addr;
    logic                         active_normal;
    logic                         load_finish;
    logic [COL_BITS-1:0]          load_length;
    logic                         err_clear;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         rd_valid;
    logic [(2**ROW_BITS)-1:0]     row_full;
    logic [ROW_BITS:0]            rows_occupied;
    logic                         overflow_err;

    modport master (
        output data_valid, data_write_addr, data_value, data_read_addr,
               active_normal, load_finish, load_length, err_clear,
        input  rd_data, rd_valid, row_full, rows_occupied, overflow_err
    );

    modport slave (
        input  data_valid, data_write_addr, data_value, data_read_addr,
               active_normal, load_finish, load_length, err_clear,
        output rd_data, rd_valid, row_full, rows_occupied, overflow_err
    );
endinterface

// File: rtl/full_st0_delay_line.sv
// ----------------------------------------------------------------------------
// full_st0_delay_line
// Fixed-depth shift register with asynchronous active-high reset. Shifts on
// every rising clock edge; DEPTH=0 degenerates to a wire.
//   clk, reset : clock / async reset (clears every stage)
//   din        : WIDTH-bit input
//   dout       : din delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module full_st0_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_q [DEPTH];
            logic [WIDTH-1:0] stage_d [DEPTH];

            // Next value of each stage is its upstream neighbour
            always_comb begin
                stage_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage_d[i] = stage_q[i-1];
                end
            end

            // Stage registers, cleared asynchronously
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_q[i] <= stage_d[i];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/full_st0_data_buffer.sv
// ----------------------------------------------------------------------------
// full_st0_data_buffer
// Data memory and read-alignment stage behind the stage-0 FIFO controller.
// Writes land at the controller's write address; reads are pipelined through
// two memory stages plus ALIGN_DELAY stages so rd_data/rd_valid line up with
// the controller's delayed active strobe (2+ALIGN_DELAY cycles). Per-row
// occupancy is tracked and a sticky flag reports writes into undrained rows.
//   clk, reset : clock / async active-high reset (memory is not reset)
//   bus        : full_st0_data_buffer_if.slave (write, read-control, status)
// Build macro FULL_ST0_BUF_BYPASS_EN: when defined, a read of the address
// being written in the same cycle returns the new data (write-first);
// otherwise the old contents are returned (read-first).
// ----------------------------------------------------------------------------
module full_st0_data_buffer
    import full_st0_data_buffer_pkg::*;
#(
    parameter int DATA_WIDTH  = BUF_DATA_WIDTH,
    parameter int ROW_BITS    = BUF_ROW_BITS,
    parameter int COL_BITS    = BUF_COL_BITS,
    parameter int ALIGN_DELAY = BUF_ALIGN_DELAY
) (
    input  logic                        clk,
    input  logic                        reset,
    full_st0_data_buffer_if.slave       bus
);

    localparam int ADDR_BITS = ROW_BITS + COL_BITS;
    localparam int NUM_WORDS = 2 ** ADDR_BITS;
    localparam int NUM_ROWS  = 2 ** ROW_BITS;

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

    logic [ROW_BITS-1:0]   wr_row_s;
    logic [ROW_BITS-1:0]   rd_row_s;
    logic [COL_BITS-1:0]   wr_col_s;

    logic                  s1_en_d,   s1_en_q;
    logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;
    logic                  s2_en_d,   s2_en_q;
    logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;

    logic [DATA_WIDTH:0]   align_out_s;

    logic                  row_set_s;
    logic                  row_clr_s;
    logic                  clr_hits_wr_row_s;
    logic                  ovf_set_s;
    logic [NUM_ROWS-1:0]   row_full_d,      row_full_q;
    logic [ROW_BITS:0]     rows_occupied_d, rows_occupied_q;
    logic                  overflow_err_d,  overflow_err_q;

    assign wr_row_s = bus.data_write_addr[ADDR_BITS-1:COL_BITS];
    assign wr_col_s = bus.data_write_addr[COL_BITS-1:0];
    assign rd_row_s = bus.data_read_addr[ADDR_BITS-1:COL_BITS];

    // Word storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (bus.data_valid) begin
            mem_q[bus.data_write_addr] <= bus.data_value;
        end
    end

    // Read stages: S1 samples the array, S2 zeroes data of disabled slots so
    // every later stage (and rd_data) already carries the valid gating
    always_comb begin
        s1_en_d = bus.active_normal;
`ifdef FULL_ST0_BUF_BYPASS_EN
        if (bus.data_valid && (bus.data_write_addr == bus.data_read_addr)) begin
            s1_data_d = bus.data_value;
        end else begin
            s1_data_d = mem_q[bus.data_read_addr];
        end
`else
        s1_data_d = mem_q[bus.data_read_addr];
`endif
        s2_en_d = s1_en_q;
        if (s1_en_q) begin
            s2_data_d = s1_data_q;
        end else begin
            s2_data_d = '0;
        end
    end

    // S1/S2 registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_en_q   <= 1'b0;
            s1_data_q <= '0;
            s2_en_q   <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s1_en_q   <= s1_en_d;
            s1_data_q <= s1_data_d;
            s2_en_q   <= s2_en_d;
            s2_data_q <= s2_data_d;
        end
    end

    full_st0_delay_line #(
        .DEPTH (ALIGN_DELAY),
        .WIDTH (DATA_WIDTH + 1)
    ) u_align (
        .clk   (clk),
        .reset (reset),
        .din   ({s2_en_q, s2_data_q}),
        .dout  (align_out_s)
    );

    // Occupancy: clear applied before set so a same-row set wins; a drain of
    // the written row in the same cycle suppresses the overflow
    always_comb begin
        row_set_s         = bus.data_valid & (wr_col_s == bus.load_length);
        row_clr_s         = bus.active_normal & bus.load_finish;
        clr_hits_wr_row_s = row_clr_s & (rd_row_s == wr_row_s);
        ovf_set_s         = bus.data_valid & row_full_q[wr_row_s] & ~clr_hits_wr_row_s;

        row_full_d = row_full_q;
        if (row_clr_s) begin
            row_full_d[rd_row_s] = 1'b0;
        end else begin
            row_full_d[rd_row_s] = row_full_q[rd_row_s];
        end
        if (row_set_s) begin
            row_full_d[wr_row_s] = 1'b1;
        end else begin
            row_full_d[wr_row_s] = row_full_d[wr_row_s];
        end

        rows_occupied_d = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            rows_occupied_d = rows_occupied_d + {{ROW_BITS{1'b0}}, row_full_d[i]};
        end

        if (ovf_set_s) begin
            overflow_err_d = 1'b1;
        end else if (bus.err_clear) begin
            overflow_err_d = 1'b0;
        end else begin
            overflow_err_d = overflow_err_q;
        end
    end

    // Occupancy and error registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_full_q      <= '0;
            rows_occupied_q <= '0;
            overflow_err_q  <= 1'b0;
        end else begin
            row_full_q      <= row_full_d;
            rows_occupied_q <= rows_occupied_d;
            overflow_err_q  <= overflow_err_d;
        end
    end

    assign bus.rd_valid      = align_out_s[DATA_WIDTH];
    assign bus.rd_data       = align_out_s[DATA_WIDTH-1:0];
    assign bus.row_full      = row_full_q;
    assign bus.rows_occupied = rows_occupied_q;
    assign bus.overflow_err  = overflow_err_q;

endmodule

// File: tb/tb_full_st0_data_buffer.sv
// ----------------------------------------------------------------------------
// tb_full_st0_data_buffer
// Directed and randomized stimulus for full_st0_data_buffer, checked every
// cycle against a queue/array reference model of the buffer's rules.
// ----------------------------------------------------------------------------
module tb_full_st0_data_buffer;
    import full_st0_data_buffer_pkg::*;

    localparam int LAT = 2 + BUF_ALIGN_DELAY;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    full_st0_data_buffer_if bus ();

    full_st0_data_buffer #(
        .DATA_WIDTH  (BUF_DATA_WIDTH),
        .ROW_BITS    (BUF_ROW_BITS),
        .COL_BITS    (BUF_COL_BITS),
        .ALIGN_DELAY (BUF_ALIGN_DELAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem [64];
    logic [7:0]  m_full;
    logic        m_ovf;
    logic [32:0] m_pipe [$];
    logic [32:0] m_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 8'h00;
        m_ovf  = 1'b0;
        m_out  = 33'h0;
        m_pipe.delete();
        for (int i = 0; i < LAT - 1; i++) m_pipe.push_back(33'h0);
    endtask

    task automatic drive(input logic dv, input logic [5:0] wa, input logic [31:0] wv,
                         input logic [5:0] ra, input logic an, input logic lf,
                         input logic [2:0] ll, input logic ec);
        bus.data_valid      = dv;
        bus.data_write_addr = wa;
        bus.data_value      = wv;
        bus.data_read_addr  = ra;
        bus.active_normal   = an;
        bus.load_finish     = lf;
        bus.load_length     = ll;
        bus.err_clear       = ec;
    endtask

    task automatic idle(input logic [2:0] ll);
        drive(1'b0, 6'h00, 32'h0, 6'h00, 1'b0, 1'b0, ll, 1'b0);
    endtask

    task automatic check_outputs();
        chk("rd_valid", {63'h0, bus.rd_valid}, {63'h0, m_out[32]});
        chk("rd_data", {32'h0, bus.rd_data}, {32'h0, m_out[31:0]});
        chk("row_full", {56'h0, bus.row_full}, {56'h0, m_full});
        chk("rows_occupied", {60'h0, bus.rows_occupied}, 64'($countones(m_full)));
        chk("overflow_err", {63'h0, bus.overflow_err}, {63'h0, m_ovf});
    endtask

    // Apply the rules to the inputs present this cycle, clock once, compare
    task automatic step();
        logic [31:0] rdv;
        logic [2:0]  wr_row;
        logic [2:0]  rd_row;
        logic        set_ev;
        logic        clr_ev;
        rdv = m_mem[bus.data_read_addr];
`ifdef FULL_ST0_BUF_BYPASS_EN
        if (bus.data_valid && (bus.data_write_addr == bus.data_read_addr)) rdv = bus.data_value;
`endif
        m_pipe.push_back(bus.active_normal ? {1'b1, rdv} : 33'h0);
        m_out  = m_pipe.pop_front();
        wr_row = addr_row(bus.data_write_addr);
        rd_row = addr_row(bus.data_read_addr);
        set_ev = bus.data_valid && (addr_col(bus.data_write_addr) == bus.load_length);
        clr_ev = bus.active_normal && bus.load_finish;
        if (bus.data_valid && m_full[wr_row] && !(clr_ev && (rd_row == wr_row))) m_ovf = 1'b1;
        else if (bus.err_clear) m_ovf = 1'b0;
        if (clr_ev) m_full[rd_row] = 1'b0;
        if (set_ev) m_full[wr_row] = 1'b1;
        if (bus.data_valid) m_mem[bus.data_write_addr] = bus.data_value;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] coll_exp;

        // Power-up reset
        reset = 1'b1;
        idle(3'd7);
        model_reset();
        #2;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Fill the whole memory so every later read has a known value
        for (int a = 0; a < 64; a++) begin
            drive(1'b1, 6'(a), $urandom, 6'h00, 1'b0, 1'b0, 3'd7, 1'b0);
            step();
        end
        idle(3'd7);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Basic latency: one read appears exactly LAT cycles later, once
        drive(1'b1, 6'h09, 32'h3F800000, 6'h00, 1'b0, 1'b0, 3'd7, 1'b0);
        step();
        drive(1'b0, 6'h00, 32'h0, 6'h09, 1'b1, 1'b0, 3'd7, 1'b0);
        for (int i = 1; i <= LAT + 1; i++) begin
            step();
            idle(3'd7);
            chk("lat_valid", {63'h0, bus.rd_valid}, (i == LAT) ? 64'h1 : 64'h0);
            chk("lat_data", {32'h0, bus.rd_data}, (i == LAT) ? 64'h3F800000 : 64'h0);
        end

        // Same-cycle read/write collision
`ifdef FULL_ST0_BUF_BYPASS_EN
        coll_exp = 32'h22222222;
`else
        coll_exp = 32'h11111111;
`endif
        drive(1'b1, 6'h05, 32'h11111111, 6'h00, 1'b0, 1'b0, 3'd7, 1'b0);
        step();
        drive(1'b1, 6'h05, 32'h22222222, 6'h05, 1'b1, 1'b0, 3'd7, 1'b0);
        for (int i = 1; i <= LAT; i++) begin
            step();
            idle(3'd7);
        end
        chk("collision_data", {32'h0, bus.rd_data}, {32'h0, coll_exp});

        // Row fill and drain (row 2, load_length 3)
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, {3'd2, 3'(c)}, $urandom, 6'h00, 1'b0, 1'b0, 3'd3, 1'b0);
            step();
        end
        chk("fill_row_full", {56'h0, bus.row_full}, 64'h04);
        chk("fill_rows_occ", {60'h0, bus.rows_occupied}, 64'h1);
        for (int c = 0; c < 4; c++) begin
            drive(1'b0, 6'h00, 32'h0, {3'd2, 3'(c)}, 1'b1, (c == 3), 3'd3, 1'b0);
            step();
        end
        chk("drain_row_full", {56'h0, bus.row_full}, 64'h00);

        // Overflow on row 1, hold, then clear
        drive(1'b1, 6'h0B, 32'hA5A5A5A5, 6'h00, 1'b0, 1'b0, 3'd3, 1'b0);
        step();
        drive(1'b1, 6'h08, 32'h5A5A5A5A, 6'h00, 1'b0, 1'b0, 3'd3, 1'b0);
        step();
        chk("ovf_set", {63'h0, bus.overflow_err}, 64'h1);
        idle(3'd3);
        step();
        chk("ovf_hold", {63'h0, bus.overflow_err}, 64'h1);
        drive(1'b0, 6'h00, 32'h0, 6'h00, 1'b0, 1'b0, 3'd3, 1'b1);
        step();
        chk("ovf_clear", {63'h0, bus.overflow_err}, 64'h0);

        // Simultaneous set and clear on row 4
        drive(1'b1, 6'h23, 32'h01234567, 6'h00, 1'b0, 1'b0, 3'd3, 1'b0);
        step();
        drive(1'b1, 6'h23, 32'h89ABCDEF, 6'h23, 1'b1, 1'b1, 3'd3, 1'b0);
        step();
        chk("setclr_row4", {63'h0, bus.row_full[4]}, 64'h1);
        chk("setclr_ovf", {63'h0, bus.overflow_err}, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 6'($urandom), $urandom, 6'($urandom),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0));
            step();
        end

        // Reset mid-stream with occupancy, an error and valid data in flight
        drive(1'b1, 6'h38, 32'hCAFEF00D, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        drive(1'b1, 6'h39, 32'hBEEF0001, 6'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        step();
        for (int i = 0; i < LAT + 4; i++) begin
            drive(1'b0, 6'h00, 32'h0, 6'($urandom), 1'b1, 1'b0, 3'd0, 1'b0);
            step();
        end
        #3;
        reset = 1'b1;
        idle(3'd0);
        #1;
        model_reset();
        chk("rst_rd_valid", {63'h0, bus.rd_valid}, 64'h0);
        chk("rst_row_full", {56'h0, bus.row_full}, 64'h0);
        chk("rst_ovf", {63'h0, bus.overflow_err}, 64'h0);
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step();
            chk("post_rst_valid", {63'h0, bus.rd_valid}, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
